// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM states and frame geometry shared by the loader and its bench.
package imem_loader_pkg;
  typedef enum logic [3:0] {IDLE, HDR_LO, HDR_HI, W0, W1, W2, CHK, DONE, ERR} state_t;
  localparam int BYTES_PER_WORD = 3;
  localparam int HDR_BYTES = 2;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: packs a framed byte stream into instruction words and writes them to imem.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int INSTR_WIDTH = 19,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int CNT_W = HDR_BYTES * 8 - 4;
  localparam int B2_SH = INSTR_WIDTH - 8 * (BYTES_PER_WORD - 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHK;
`else
  localparam state_t END_ST = DONE;
`endif
  state_t state, state_n;
  logic [7:0] cnt_lo, b0, b1, csum;
  logic [CNT_W-1:0] n, k, n_hdr;
  logic xfer, wr, b2_bad, hdr_bad;
  assign busy = !(state inside {IDLE, DONE, ERR});
  assign in_ready = busy;
  assign done = state == DONE;
  assign err = state == ERR;
  assign cpu_hold = !(state inside {IDLE, DONE});
  assign xfer = in_valid && in_ready;
  assign n_hdr = {in_data[3:0], cnt_lo};
  assign b2_bad = |(in_data >> B2_SH);
  // The range check guarantees the write address never wraps.
  assign hdr_bad = |in_data[7:4] || (32'(BASE_ADDR) + 32'(n_hdr) > (32'd1 << ADDR_WIDTH));
  always_comb begin
    state_n = state;
    wr = 1'b0;
    case (state)
      IDLE, DONE, ERR: state_n = start ? HDR_LO : state;
      HDR_LO: state_n = xfer ? HDR_HI : state;
      HDR_HI: state_n = !xfer ? state : hdr_bad ? ERR : n_hdr == '0 ? END_ST : W0;
      W0: state_n = xfer ? W1 : state;
      W1: state_n = xfer ? W2 : state;
      W2: begin
        wr = xfer && !b2_bad;
        state_n = !xfer ? state : b2_bad ? ERR : k == n - 1'b1 ? END_ST : W0;
      end
      CHK: state_n = !xfer ? state : in_data == csum ? DONE : ERR;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt_lo <= '0;
      b0 <= '0;
      b1 <= '0;
      csum <= '0;
      n <= '0;
      k <= '0;
      wr_en <= 1'b0;
      wr_addr <= ADDR_WIDTH'(BASE_ADDR);
      wr_data <= '0;
    end else begin
      state <= state_n;
      wr_en <= wr;
      csum <= (start && !busy) ? '0 : xfer ? csum ^ in_data : csum;
      if (xfer && state == HDR_LO) cnt_lo <= in_data;
      if (xfer && state == HDR_HI) begin
        n <= n_hdr;
        k <= '0;
      end
      if (xfer && state == W0) b0 <= in_data;
      if (xfer && state == W1) b1 <= in_data;
      if (wr) begin
        wr_addr <= ADDR_WIDTH'(32'(BASE_ADDR) + 32'(k));
        wr_data <= {in_data[INSTR_WIDTH-17:0], b1, b0};
        k <= k + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against imem_loader with a write scoreboard.
// Checksum frames are exercised when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, wr_en, cpu_hold, busy, done, err;
  logic [11:0] wr_addr;
  logic [18:0] wr_data;
  typedef struct {
    logic [11:0] a;
    logic [18:0] d;
  } wr_t;
  wr_t pend[$];
  int checks = 0;
  int failures = 0;
  logic [7:0] acc;
  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Advance to the next falling edge and reconcile the write strobe with the scoreboard.
  task automatic step();
    wr_t e;
    @(negedge clk);
    if (pend.size() > 0) begin
      e = pend.pop_front();
      chk("wr_en", 32'(wr_en), 32'd1);
      chk("wr_addr", 32'(wr_addr), 32'(e.a));
      chk("wr_data", 32'(wr_data), 32'(e.d));
    end else chk("wr_en_quiet", 32'(wr_en), 32'd0);
  endtask
  task automatic send(input logic [7:0] b, input int gap, input logic w,
                      input logic [11:0] a, input logic [18:0] d);
    repeat (gap) step();
    in_data = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    chk("in_ready_xfer", 32'(in_ready), 32'd1);
    if (in_ready) begin
      acc ^= b;
      if (w) pend.push_back('{a, d});
    end
    step();
    in_valid = 1'b0;
    in_data = '0;
  endtask
  task automatic word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input int gap, input logic ok, input logic [11:0] a);
    send(b0, gap, 1'b0, '0, '0);
    send(b1, gap, 1'b0, '0, '0);
    send(b2, gap, ok, a, {b2[2:0], b1, b0});
  endtask
  task automatic arm();
    start = 1'b1;
    acc = '0;
    step();
    start = 1'b0;
    chk("armed_busy", 32'(busy), 32'd1);
    chk("armed_hold", 32'(cpu_hold), 32'd1);
    chk("armed_err", 32'(err), 32'd0);
    chk("armed_done", 32'(done), 32'd0);
  endtask
  task automatic finish_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(acc, 0, 1'b0, '0, '0);
`endif
    chk("done", 32'(done), 32'd1);
    chk("done_hold", 32'(cpu_hold), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_ready", 32'(in_ready), 32'd0);
    chk("done_err", 32'(err), 32'd0);
  endtask
  task automatic chk_reset();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
  endtask
  task automatic chk_err();
    chk("err", 32'(err), 32'd1);
    chk("err_ready", 32'(in_ready), 32'd0);
    chk("err_hold", 32'(cpu_hold), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
  endtask
  task automatic test1();
    arm();
    send(8'h02, 0, 1'b0, '0, '0);
    send(8'h00, 0, 1'b0, '0, '0);
    word(8'h34, 8'h12, 8'h05, 0, 1'b1, 12'd0);
    word(8'hFF, 8'hFF, 8'h07, 0, 1'b1, 12'd1);
    finish_frame();
  endtask
  initial begin
    acc = '0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b1;
    step();
    chk_reset();
    test1();
    // N=1 with in_valid low every other cycle; a start mid-frame must be ignored
    arm();
    send(8'h01, 1, 1'b0, '0, '0);
    send(8'h00, 1, 1'b0, '0, '0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored", 32'(busy), 32'd1);
    word(8'hAA, 8'hBB, 8'h03, 1, 1'b1, 12'd0);
    repeat (2) step();
    finish_frame();
    // largest legal count is accepted; nibble-high count bits are rejected
    arm();
    send(8'hFF, 0, 1'b0, '0, '0);
    send(8'h0F, 0, 1'b0, '0, '0);
    chk("n4095_busy", 32'(busy), 32'd1);
    chk("n4095_err", 32'(err), 32'd0);
    chk("n4095_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    arm();
    send(8'h00, 0, 1'b0, '0, '0);
    send(8'h10, 0, 1'b0, '0, '0);
    chk_err();
    arm();
    send(8'h00, 0, 1'b0, '0, '0);
    send(8'h20, 0, 1'b0, '0, '0);
    chk_err();
    repeat (3) step();
    // bad top bits in byte 2 of word 1: word 0 stands, nothing else written
    arm();
    send(8'h03, 0, 1'b0, '0, '0);
    send(8'h00, 0, 1'b0, '0, '0);
    word(8'h01, 8'h02, 8'h03, 0, 1'b1, 12'd0);
    word(8'h04, 8'h05, 8'h08, 0, 1'b0, 12'd1);
    chk_err();
    repeat (4) step();
    arm();
    // asynchronous reset partway through word 2 of a three-word frame
    send(8'h03, 0, 1'b0, '0, '0);
    send(8'h00, 0, 1'b0, '0, '0);
    word(8'h11, 8'h22, 8'h01, 0, 1'b1, 12'd0);
    word(8'h33, 8'h44, 8'h02, 0, 1'b1, 12'd1);
    send(8'h55, 0, 1'b0, '0, '0);
    #2 rst = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    chk_reset();
    rst = 1'b1;
    step();
    test1();
`ifdef IMEM_LOADER_CHECKSUM_EN
    arm();
    send(8'h01, 0, 1'b0, '0, '0);
    send(8'h00, 0, 1'b0, '0, '0);
    word(8'h11, 8'h22, 8'h03, 0, 1'b1, 12'd0);
    send(8'h31, 0, 1'b0, '0, '0);
    chk("chk_good_done", 32'(done), 32'd1);
    arm();
    send(8'h01, 0, 1'b0, '0, '0);
    send(8'h00, 0, 1'b0, '0, '0);
    word(8'h11, 8'h22, 8'h03, 0, 1'b1, 12'd0);
    send(8'h30, 0, 1'b0, '0, '0);
    chk_err();
    arm();
    send(8'h00, 0, 1'b0, '0, '0);
    send(8'h00, 0, 1'b0, '0, '0);
    send(8'h00, 0, 1'b0, '0, '0);
    chk("chk_n0_done", 32'(done), 32'd1);
`else
    arm();
    send(8'h00, 0, 1'b0, '0, '0);
    send(8'h00, 0, 1'b0, '0, '0);
    chk("n0_done", 32'(done), 32'd1);
`endif
    repeat (2) step();
    chk("pending", 32'(pend.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
